// File: rtl/counter_load_sequencer_if.sv
// ---------------------------------------------------------------------------
// counter_load_sequencer_if
//
// Purpose: groups the command handshake and the counter drive bus of the
// counter load sequencer into one bundle.
//
// Signals:
//   cmd_valid  command present (master -> slave)
//   cmd_ready  sequencer can accept a command (slave -> master)
//   cmd_start  value to load into the counter
//   cmd_len    number of count-enable pulses to issue
//   cmd_div    count-enable spacing minus one (0 = every cycle)
//   abort      synchronous cancel of the command in progress
//   ld         counter load strobe
//   ce         counter count-enable
//   d          counter load data
//
// Modports:
//   master  command issuer / counter observer
//   slave   the sequencer itself
// ---------------------------------------------------------------------------
interface counter_load_sequencer_if #(
  parameter int W     = 16,
  parameter int LEN_W = 16,
  parameter int DIV_W = 8
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [W-1:0]     cmd_start;
  logic [LEN_W-1:0] cmd_len;
  logic [DIV_W-1:0] cmd_div;
  logic             abort;
  logic             ld;
  logic             ce;
  logic [W-1:0]     d;

  modport master (
    output cmd_valid, cmd_start, cmd_len, cmd_div, abort,
    input  cmd_ready, ld, ce, d
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_len, cmd_div, abort,
    output cmd_ready, ld, ce, d
  );

endinterface

// File: rtl/counter_load_sequencer.sv
// ---------------------------------------------------------------------------
// counter_load_sequencer
//
// Purpose: upstream control stage for a loadable up-counter. Accepts one
// command (start value, pulse count, prescale divisor) per valid/ready
// handshake, strobes a one-cycle load of the start value, then issues
// exactly LEN count-enable pulses spaced DIV+1 cycles apart and finally
// pulses DONE for one cycle.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low reset
//   bus      counter_load_sequencer_if.slave (command handshake + counter bus)
//   busy_o   high while loading or running
//   done_o   one-cycle completion pulse
//
// Optional feature (macro COUNTER_LOAD_SEQUENCER_SHADOW_EN):
//   exp_q_o  shadow copy of the value the counter should hold
//   wrap_o   sticky flag, set when the shadow value wraps from all-ones to 0,
//            cleared on the next command accept
// ---------------------------------------------------------------------------
module counter_load_sequencer #(
  parameter int W     = 16,
  parameter int LEN_W = 16,
  parameter int DIV_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  counter_load_sequencer_if.slave bus,
  output logic                    busy_o,
  output logic                    done_o
`ifdef COUNTER_LOAD_SEQUENCER_SHADOW_EN
  ,
  output logic [W-1:0]            exp_q_o,
  output logic [0:0]              wrap_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_e;

  state_e           state_q;
  logic [W-1:0]     d_q;
  logic [LEN_W-1:0] rem_q;
  logic [DIV_W-1:0] pre_q;
  logic [DIV_W-1:0] div_q;

  logic cmdFire;
  logic ceHit;

  // A command is taken only in IDLE and never while ABORT is high, which
  // is exactly the condition advertised on cmd_ready.
  assign cmdFire = (state_q == IDLE) && bus.cmd_valid && !bus.abort;

  // The prescaler counts up from 0 after RUN entry and fires when it
  // reaches the latched divisor, so the first pulse lands div cycles in.
  assign ceHit = (state_q == RUN) && (pre_q == div_q);

  // Sequencer FSM together with its counters. rem_q holds the pulses still
  // owed, pre_q the cycles since the last pulse (or since RUN entry).
  // ABORT only matters in LOAD and RUN; the LD/CE of the abort cycle
  // itself are still driven because outputs decode the current state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      d_q     <= '0;
      rem_q   <= '0;
      pre_q   <= '0;
      div_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmdFire) begin
            d_q     <= bus.cmd_start;
            rem_q   <= bus.cmd_len;
            div_q   <= bus.cmd_div;
            pre_q   <= '0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (bus.abort) begin
            state_q <= IDLE;
          end else if (rem_q == '0) begin
            state_q <= FIN;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (ceHit) begin
            pre_q <= '0;
            rem_q <= rem_q - LEN_W'(1);
          end else begin
            pre_q <= pre_q + DIV_W'(1);
          end
          if (bus.abort) begin
            state_q <= IDLE;
          end else if (ceHit && (rem_q == LEN_W'(1))) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Moore decode of the outputs; ABORT is the only input that reaches an
  // output, and only through cmd_ready.
  assign bus.cmd_ready = (state_q == IDLE) && !bus.abort;
  assign bus.ld        = (state_q == LOAD);
  assign bus.ce        = ceHit;
  assign bus.d         = d_q;
  assign busy_o        = (state_q == LOAD) || (state_q == RUN);
  assign done_o        = (state_q == FIN);

`ifdef COUNTER_LOAD_SEQUENCER_SHADOW_EN
  logic [W-1:0] exp_q;
  logic         wrap_q;

  // Shadow of the downstream counter: it takes the start value on the
  // load edge and follows every count-enable, wrapping modulo 2^W. The
  // wrap flag is sticky for the whole command and cleared on the next
  // accept so software can read it after DONE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      if (cmdFire) begin
        wrap_q <= 1'b0;
      end
      if (state_q == LOAD) begin
        exp_q <= d_q;
      end else if (ceHit) begin
        exp_q <= exp_q + W'(1);
        if (&exp_q) begin
          wrap_q <= 1'b1;
        end
      end
    end
  end

  assign exp_q_o = exp_q;
  assign wrap_o  = wrap_q;
`endif

endmodule

// File: doc/counter_load_sequencer.md
Name: counter_load_sequencer

Overview:
- Upstream control stage for the team's 16-bit loadable up-counter (ports LD, CE, D).
- Accepts one command per valid/ready handshake: start value, count length and prescale divisor.
- For each command: drives a one-cycle load of the start value, then issues exactly LEN count-enable pulses spaced DIV+1 cycles apart, then reports completion.
- Sits between the command/register interface and the counter, which it drives directly.

Parameters:
- W, 16, width of start value and D output (matches counter width)
- LEN_W, 16, width of CMD_LEN and the internal remaining-pulse counter
- DIV_W, 8, width of CMD_DIV and the internal prescale counter

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- CMD_VALID  input  1  command present
- CMD_READY  output  1  sequencer can accept; equals (state==IDLE) & ~ABORT
- CMD_START  input  W  value to load into counter
- CMD_LEN  input  LEN_W  number of CE pulses to issue
- CMD_DIV  input  DIV_W  CE spacing minus one (0 = every cycle)
- ABORT  input  1  synchronous cancel of the command in progress
- LD  output  1  counter load strobe
- CE  output  1  counter count-enable
- D  output  W  counter load data
- BUSY  output  1  high in LOAD and RUN
- DONE  output  1  one-cycle completion pulse

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE; D, prescale count, remaining count and latched DIV all cleared to 0.
  - LD=CE=BUSY=DONE=0.
  - CMD_READY=1 once RST_N is high.
- Outputs are Moore-decoded from registered state and counters. The only input in any output path is ABORT, and only in CMD_READY.
- FSM states: IDLE, LOAD, RUN, FIN.
- IDLE:
  - Handshake fires on an edge with CMD_VALID & CMD_READY.
  - On fire: latch CMD_START into D, CMD_LEN into rem, CMD_DIV into div; clear pre; go to LOAD.
- LOAD:
  - LD=1 for exactly one cycle, D=start value.
  - If rem==0, go to FIN; otherwise go to RUN.
- RUN:
  - CE=1 in a cycle iff pre==div.
  - On a CE cycle: pre<=0 and rem<=rem-1. On other cycles: pre<=pre+1.
  - On the CE cycle where rem==1: go to FIN.
  - First CE occurs div cycles after RUN entry. With div=0 there are LEN consecutive CE cycles.
- FIN: DONE=1 for one cycle, then IDLE. CMD_READY returns in the following cycle.
- Latency with div=0 (accept edge = cycle 0): LD in cycle 1, CE in cycles 2..LEN+1, DONE in cycle LEN+2.
- D holds the last loaded value until the next accept.
- BUSY=1 in LOAD and RUN; 0 in IDLE and FIN.
- ABORT:
  - Sampled at the edge, in LOAD or RUN: next state IDLE, no DONE. LD/CE asserted in the abort cycle itself still occur.
  - In IDLE: ABORT forces CMD_READY=0, so a simultaneous CMD_VALID is not accepted.
  - In FIN: ignored; DONE still pulses.
- CMD_VALID while not ready: ignored. The inputs need not be held stable.
- Maximum values:
  - LEN = 2^LEN_W-1 produces exactly that many CE pulses.
  - DIV = 2^DIV_W-1 gives 2^DIV_W cycles between pulses.
- Reset mid-operation: immediate return to reset values; no DONE.

Optional Feature:
- Macro: COUNTER_LOAD_SEQUENCER_SHADOW_EN.
- When defined:
  - Adds output EXP_Q[W-1:0]: expected counter value, loaded from CMD_START on the LD cycle's edge and incremented modulo 2^W on each CE edge.
  - Adds output WRAP[0:0]: sticky flag set when EXP_Q increments from all-ones to 0. Cleared on the next command accept or on reset.
  - Both are 0 on reset.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Basic run: reset, then accept START=0x1234, LEN=3, DIV=0.
  - Expect LD=1 and D=0x1234 in cycle 1; CE in cycles 2,3,4; DONE in cycle 5; CMD_READY=1 in cycle 6.
  - With shadow enabled, EXP_Q=0x1237.
- Prescale: START=0, LEN=2, DIV=2 → CE only in RUN cycles 3 and 6 (relative to RUN entry = 1). DONE the cycle after the second CE. Exactly 2 CE pulses total.
- Zero length: LEN=0, START=0xABCD → LD with D=0xABCD for one cycle, DONE the next cycle, zero CE pulses. BUSY high for exactly one cycle.
- Wrap (shadow enabled): START=0xFFFE, LEN=3 → EXP_Q ends at 0x0001 and WRAP=1. Next accept clears WRAP.
- Abort and back-to-back:
  - Assert ABORT after 2 of LEN=10 pulses → no further CE and no DONE; IDLE next cycle.
  - In IDLE, ABORT with CMD_VALID same cycle → not accepted.
  - CMD_VALID held while busy → no second command until READY.
- Reset mid-run: drop RST_N during RUN with LEN=100 → LD/CE/BUSY/DONE go 0 immediately (asynchronously); after release, CMD_READY=1 and D=0.
